// File: rtl/aes_arb_pkg.sv
// aes_arb_pkg: shared widths, arbiter state encoding and tag sizing for aes_req_arbiter.
// Imported by aes_tag_fifo and aes_req_arbiter.
package aes_arb_pkg;

  localparam int DATA_W_DEF  = 128;
  localparam int KEY_L_DEF   = 128;
  localparam int NUM_REQ_DEF = 4;
  localparam int MAX_OUT_DEF = 16;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    FLUSHED = 2'd2
  } arb_state_e;

  typedef logic [$clog2(NUM_REQ_DEF)-1:0] tag_t;

  // A single requester still needs a 1-bit tag so the FIFO has a non-zero width.
  function automatic int tag_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/aes_tag_fifo.sv
// aes_tag_fifo: synchronous FIFO recording which requester owns each operation in the core.
// Read data is the head entry, valid whenever o_empty is low.
module aes_tag_fifo
  import aes_arb_pkg::*;
#(
  parameter int DEPTH = MAX_OUT_DEF,
  parameter int W     = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && (r_count != CNT_W'(DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: round-robin front end sharing one pipelined AES-128 core among NUM_REQ requesters.
// Defining AES_ARB_PERF_EN adds the grant_cnt port with saturating per-requester handshake counters.
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MAX_OUT = 16,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int KEY_L   = KEY_L_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*KEY_L-1:0]  req_key,
  input  logic [NUM_REQ*DATA_W-1:0] req_text,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_text,
  output logic                      aes_valid_in,
  output logic [KEY_L-1:0]          aes_cipher_key,
  output logic [DATA_W-1:0]         aes_plain_text,
  input  logic [DATA_W-1:0]         aes_cipher_text,
  input  logic                      aes_valid_out,
  input  logic                      flush_req,
  output logic                      flush_done,
  output logic                      busy,
  output logic                      err_orphan
`ifdef AES_ARB_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

  localparam int TAG_W = tag_width(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [TAG_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_text;
  logic               r_aes_valid_in;
  logic [KEY_L-1:0]   r_aes_key;
  logic [DATA_W-1:0]  r_aes_text;
  logic               r_err_orphan;

  logic [TAG_W-1:0]   w_cand;
  logic [TAG_W-1:0]   w_winner;
  logic               w_found;
  logic               w_grant;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_pop;
  logic [TAG_W-1:0]   w_tag_out;
  logic [CNT_W-1:0]   w_count;
  logic               w_empty;
  logic               w_full;

  aes_tag_fifo #(
    .DEPTH (MAX_OUT),
    .W     (TAG_W)
  ) u_tag_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_grant),
    .i_data  (w_winner),
    .i_pop   (w_pop),
    .o_data  (w_tag_out),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Search starts at the pointer and wraps; the first valid requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = TAG_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  always_comb begin
    w_grant = w_found && (r_state == RUN) && !w_full;
    w_ready = '0;
    if (w_grant) begin
      w_ready[w_winner] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (flush_req) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!flush_req)          w_state_nxt = RUN;
        else if (w_count == '0) w_state_nxt = FLUSHED;
      end
      FLUSHED: begin
        if (!flush_req) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // A result arriving with nothing in flight is flagged and otherwise ignored.
  assign w_pop = aes_valid_out && !w_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= RUN;
      r_ptr          <= '0;
      r_rsp_valid    <= '0;
      r_rsp_text     <= '0;
      r_aes_valid_in <= 1'b0;
      r_aes_key      <= '0;
      r_aes_text     <= '0;
      r_err_orphan   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_aes_valid_in <= w_grant;
      if (w_grant) begin
        r_ptr      <= (w_winner == TAG_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
        r_aes_key  <= req_key[int'(w_winner) * KEY_L +: KEY_L];
        r_aes_text <= req_text[int'(w_winner) * DATA_W +: DATA_W];
      end
      r_rsp_valid <= '0;
      if (w_pop) begin
        r_rsp_valid[w_tag_out] <= 1'b1;
        r_rsp_text             <= aes_cipher_text;
      end
      if (aes_valid_out && w_empty) begin
        r_err_orphan <= 1'b1;
      end
    end
  end

  assign req_ready      = w_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_text       = r_rsp_text;
  assign aes_valid_in   = r_aes_valid_in;
  assign aes_cipher_key = r_aes_key;
  assign aes_plain_text = r_aes_text;
  assign flush_done     = (r_state == FLUSHED);
  assign busy           = (w_count != '0);
  assign err_orphan     = r_err_orphan;

`ifdef AES_ARB_PERF_EN
  logic [15:0] r_grant_cnt [NUM_REQ];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_ready[i] && req_valid[i] && (r_grant_cnt[i] != 16'hFFFF)) begin
          r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*16 +: 16] = r_grant_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb_aes_req_arbiter: directed scoreboard bench for aes_req_arbiter with a fixed-latency core model.
// Stimulus pushes expected grants/responses; independent monitors pop and compare.
module tb_aes_req_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int MAX_OUT  = 16;
  localparam int DATA_W   = 128;
  localparam int KEY_L    = 128;
  localparam int CORE_LAT = 4;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_TXT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct { int req; logic [127:0] key; logic [127:0] text; } reqItem_t;
  typedef struct { int tag; logic [127:0] text; } rspItem_t;
  typedef struct { logic [127:0] text; int rel; } coreItem_t;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*KEY_L-1:0]  req_key = '0;
  logic [NUM_REQ*DATA_W-1:0] req_text = '0;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_text;
  logic                      aes_valid_in;
  logic [KEY_L-1:0]          aes_cipher_key;
  logic [DATA_W-1:0]         aes_plain_text;
  logic [DATA_W-1:0]         aes_cipher_text = '0;
  logic                      aes_valid_out = 1'b0;
  logic                      flush_req = 1'b0;
  logic                      flush_done;
  logic                      busy;
  logic                      err_orphan;
`ifdef AES_ARB_PERF_EN
  logic [NUM_REQ*16-1:0]     grant_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  reqItem_t  pend[$];
  int        expGrant[$];
  rspItem_t  expRsp[$];
  int        hsCycles[$];
  coreItem_t coreQ[$];
  logic      coreHold = 1'b0;
  logic      forceOrphan = 1'b0;
  logic      checkLat = 1'b0;

  aes_req_arbiter #(
    .NUM_REQ (NUM_REQ),
    .MAX_OUT (MAX_OUT),
    .DATA_W  (DATA_W),
    .KEY_L   (KEY_L)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_key         (req_key),
    .req_text        (req_text),
    .rsp_valid       (rsp_valid),
    .rsp_text        (rsp_text),
    .aes_valid_in    (aes_valid_in),
    .aes_cipher_key  (aes_cipher_key),
    .aes_plain_text  (aes_plain_text),
    .aes_cipher_text (aes_cipher_text),
    .aes_valid_out   (aes_valid_out),
    .flush_req       (flush_req),
    .flush_done      (flush_done),
    .busy            (busy),
    .err_orphan      (err_orphan)
`ifdef AES_ARB_PERF_EN
    ,
    .grant_cnt       (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Stand-in for the AES core: the known-answer vector maps to its published ciphertext,
  // anything else to an easily recognised scramble.
  function automatic logic [127:0] coreModel(input logic [127:0] k, input logic [127:0] t);
    if (k == FIPS_KEY && t == FIPS_TXT) return FIPS_CT;
    return k ^ t ^ 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present the oldest pending item of every requester on its input slice.
  task automatic refreshReq();
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < pend.size(); j++) begin
        if (pend[j].req == i) begin
          v[i] = 1'b1;
          req_key[i*KEY_L +: KEY_L]    = pend[j].key;
          req_text[i*DATA_W +: DATA_W] = pend[j].text;
          break;
        end
      end
    end
    req_valid = v;
  endtask

  task automatic applyStimulus(input int r, input logic [127:0] k, input logic [127:0] t);
    reqItem_t it;
    rspItem_t rs;
    it.req = r; it.key = k; it.text = t;
    rs.tag = r; rs.text = coreModel(k, t);
    pend.push_back(it);
    expGrant.push_back(r);
    expRsp.push_back(rs);
    refreshReq();
  endtask

  task automatic applyReset();
    reset_n   = 1'b0;
    flush_req = 1'b0;
    coreHold  = 1'b0;
    pend.delete();
    expGrant.delete();
    expRsp.delete();
    hsCycles.delete();
    coreQ.delete();
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic waitIdle(input string name, input int maxCyc);
    int n;
    n = 0;
    while ((pend.size() > 0 || expRsp.size() > 0 || coreQ.size() > 0) && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checkOutput({name, "_drained"}, 128'(pend.size() + expRsp.size()), 128'(0));
  endtask

  // Requester driver: items handshaken in a cycle are retired just after the edge.
  initial begin : driver
    logic [NUM_REQ-1:0] hs;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i]) begin
          for (int j = 0; j < pend.size(); j++) begin
            if (pend[j].req == i) begin
              pend.delete(j);
              break;
            end
          end
        end
      end
      refreshReq();
    end
  end

  // Core model: captures each issue and returns it CORE_LAT cycles later unless held.
  initial begin : coreProc
    coreItem_t ci;
    forever begin
      @(negedge clk);
      if (aes_valid_in) begin
        ci.text = coreModel(aes_cipher_key, aes_plain_text);
        ci.rel  = cyc + CORE_LAT;
        coreQ.push_back(ci);
      end
      if (forceOrphan) begin
        aes_valid_out   = 1'b1;
        aes_cipher_text = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
        forceOrphan     = 1'b0;
      end else if (!coreHold && coreQ.size() > 0 && coreQ[0].rel <= cyc) begin
        aes_valid_out   = 1'b1;
        aes_cipher_text = coreQ[0].text;
        void'(coreQ.pop_front());
      end else begin
        aes_valid_out = 1'b0;
      end
    end
  end

  // Grant monitor: every visible grant must match the next expected requester.
  initial begin : grantMon
    forever begin
      @(negedge clk);
      if (reset_n && req_ready != '0) begin
        hsCycles.push_back(cyc);
        if (expGrant.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_grant: got %b expected none", req_ready);
        end else begin
          int g;
          g = expGrant.pop_front();
          checkOutput("grant", 128'(req_ready), 128'(1) << g);
        end
      end
    end
  end

  // Response monitor: owner strobe, data and (when enabled) end-to-end latency.
  initial begin : rspMon
    forever begin
      @(negedge clk);
      if (reset_n && rsp_valid != '0) begin
        if (expRsp.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_rsp: got %b %h expected none", rsp_valid, rsp_text);
        end else begin
          rspItem_t e;
          int h;
          e = expRsp.pop_front();
          checkOutput("rsp_valid", 128'(rsp_valid), 128'(1) << e.tag);
          checkOutput("rsp_text", rsp_text, e.text);
          if (hsCycles.size() > 0) begin
            h = hsCycles.pop_front();
            if (checkLat) checkOutput("rsp_latency", 128'(cyc), 128'(h + CORE_LAT + 2));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int n;

    // Reset values
    applyReset();
    checkOutput("rst_req_ready", 128'(req_ready), 128'(0));
    checkOutput("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    checkOutput("rst_rsp_text", rsp_text, 128'(0));
    checkOutput("rst_aes_valid_in", 128'(aes_valid_in), 128'(0));
    checkOutput("rst_aes_key", aes_cipher_key, 128'(0));
    checkOutput("rst_aes_text", aes_plain_text, 128'(0));
    checkOutput("rst_flush_done", 128'(flush_done), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_err_orphan", 128'(err_orphan), 128'(0));

    // Single request, known-answer vector
    checkLat = 1'b1;
    @(posedge clk); #1;
    applyStimulus(0, FIPS_KEY, FIPS_TXT);
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (req_ready != '0) break;
    end
    checkOutput("t1_ready", 128'(req_ready), 128'(1));
    @(negedge clk);
    checkOutput("t1_valid_in", 128'(aes_valid_in), 128'(1));
    checkOutput("t1_key", aes_cipher_key, FIPS_KEY);
    checkOutput("t1_text", aes_plain_text, FIPS_TXT);
    checkOutput("t1_busy", 128'(busy), 128'(1));
    @(negedge clk);
    checkOutput("t1_valid_in_low", 128'(aes_valid_in), 128'(0));
    checkOutput("t1_key_hold", aes_cipher_key, FIPS_KEY);
    waitIdle("t1", 40);
    checkOutput("t1_busy_idle", 128'(busy), 128'(0));

    // All requesters continuously valid: grants 0,1,2,3,0,1,2,3
    applyReset();
    checkLat = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        applyStimulus(i, {96'h0, 32'h1000 + 32'(i * 16 + r)}, {96'hc0ffee, 32'h2000 + 32'(i * 16 + r)});
      end
    end
    waitIdle("t2", 60);

    // Core stalled: 16 issue, 17th waits for the first return
    applyReset();
    checkLat = 1'b0;
    coreHold = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(0, {96'h0, 32'h3000 + 32'(i)}, {96'hbeef, 32'h4000 + 32'(i)});
    end
    repeat (24) @(negedge clk);
    checkOutput("t3_full_ready", 128'(req_ready), 128'(0));
    checkOutput("t3_full_busy", 128'(busy), 128'(1));
    checkOutput("t3_pending", 128'(pend.size()), 128'(1));
    @(posedge clk); #1;
    coreHold = 1'b0;
    @(negedge clk);
    checkOutput("t3_pop_cycle_ready", 128'(req_ready), 128'(0));
    @(negedge clk);
    checkOutput("t3_unblock_ready", 128'(req_ready), 128'(1));
    @(negedge clk);
    checkOutput("t3_17th_issue", 128'(aes_valid_in), 128'(1));
    checkOutput("t3_17th_text", aes_plain_text, {96'hbeef, 32'h4010});
    waitIdle("t3", 80);

    // Flush with 5 in flight
    applyReset();
    checkLat = 1'b0;
    coreHold = 1'b1;
    @(posedge clk); #1;
    applyStimulus(0, 128'h50, 128'h60);
    applyStimulus(1, 128'h51, 128'h61);
    applyStimulus(2, 128'h52, 128'h62);
    applyStimulus(3, 128'h53, 128'h63);
    applyStimulus(0, 128'h54, 128'h64);
    repeat (10) @(negedge clk);
    checkOutput("t4_busy", 128'(busy), 128'(1));
    checkOutput("t4_issued", 128'(pend.size()), 128'(0));
    @(posedge clk); #1;
    flush_req = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1, 128'h55, 128'h65);
    repeat (4) begin
      @(negedge clk);
      checkOutput("t4_drain_ready", 128'(req_ready), 128'(0));
    end
    checkOutput("t4_drain_flush_done", 128'(flush_done), 128'(0));
    @(posedge clk); #1;
    coreHold = 1'b0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkOutput("t4_busy_low", 128'(busy), 128'(0));
    checkOutput("t4_flush_done_late", 128'(flush_done), 128'(0));
    @(negedge clk);
    checkOutput("t4_flush_done", 128'(flush_done), 128'(1));
    checkOutput("t4_flushed_ready", 128'(req_ready), 128'(0));
    @(posedge clk); #1;
    flush_req = 1'b0;
    for (n = 0; n < 5; n++) begin
      @(negedge clk);
      if (req_ready != '0) break;
    end
    checkOutput("t4_resume", 128'(req_ready), 128'(2));
    waitIdle("t4", 40);

    // Orphan result
    applyReset();
    @(posedge clk); #1;
    forceOrphan = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5_orphan", 128'(err_orphan), 128'(1));
    checkOutput("t5_no_rsp", 128'(rsp_valid), 128'(0));
    checkOutput("t5_busy", 128'(busy), 128'(0));
    repeat (3) @(negedge clk);
    checkOutput("t5_orphan_sticky", 128'(err_orphan), 128'(1));
    applyReset();
    checkOutput("t5_orphan_cleared", 128'(err_orphan), 128'(0));

`ifdef AES_ARB_PERF_EN
    // Grant counters
    applyReset();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) applyStimulus(2, 128'h70 + 128'(i), 128'h80 + 128'(i));
    waitIdle("t6", 40);
    checkOutput("t6_cnt0", 128'(grant_cnt[15:0]), 128'(0));
    checkOutput("t6_cnt1", 128'(grant_cnt[31:16]), 128'(0));
    checkOutput("t6_cnt2", 128'(grant_cnt[47:32]), 128'(3));
    checkOutput("t6_cnt3", 128'(grant_cnt[63:48]), 128'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
